// File: rtl/vischain_ctrl.sv
// vischain_ctrl: loads a correlator visibility chain on done_i and drains it onto a valid/ready stream
module vischain_ctrl #(
  parameter int LENGTH = 3,
  parameter int WIDTH  = 7,
  parameter int FBITS  = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             done_i,
  output logic             chain_load_o,
  output logic             chain_shift_o,
  input  logic             chain_valid_i,
  input  logic [WIDTH-1:0] chain_data_i,
  output logic             m_tvalid_o,
  input  logic             m_tready_i,
  output logic             m_tlast_o,
  output logic [WIDTH-1:0] m_tdata_o,
  output logic             busy_o,
  output logic             overflow_o,
  output logic [FBITS-1:0] frames_o
);
  localparam int WORDS = 2 * LENGTH;
  localparam int IW = (WORDS > 1) ? $clog2(WORDS) : 1;
  typedef enum logic [1:0] {IDLE, LOAD, DRAIN} state_t;
  state_t state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [FBITS-1:0] frames_q, frames_d;
  logic overflow_q, overflow_d;
  logic hs, last_hs;
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      frames_q   <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      frames_q   <= frames_d;
      overflow_q <= overflow_d;
    end
  end
  // A strobe landing on the final handshake relaunches instead of being dropped.
  always_comb begin
    state_d = state_q == IDLE  ? (done_i ? LOAD : IDLE) :
              state_q == LOAD  ? DRAIN :
              state_q == DRAIN ? (last_hs ? (done_i ? LOAD : IDLE) : DRAIN) :
              IDLE;
    idx_d = (state_q == LOAD || last_hs) ? '0 : hs ? idx_q + 1'b1 : idx_q;
    frames_d = frames_q + FBITS'(last_hs);
    overflow_d = overflow_q | (done_i & (state_q != IDLE) & ~last_hs);
  end
  always_comb begin
    chain_load_o  = state_q == LOAD;
    m_tvalid_o    = (state_q == DRAIN) & chain_valid_i;
    m_tdata_o     = chain_data_i;
    m_tlast_o     = m_tvalid_o & (idx_q == IW'(WORDS - 1));
    hs            = m_tvalid_o & m_tready_i;
    last_hs       = hs & m_tlast_o;
    chain_shift_o = hs;
    busy_o        = state_q != IDLE;
    overflow_o    = overflow_q;
    frames_o      = frames_q;
  end
endmodule

// File: tb/tb_vischain_ctrl.sv
// tb_vischain_ctrl: directed checks of vischain_ctrl against a behavioural 6-word chain
module tb_vischain_ctrl;
  logic clock = 1'b0;
  logic reset, done_i, chain_valid_i, m_tready_i;
  logic [6:0] chain_data_i, m_tdata_o;
  logic chain_load_o, chain_shift_o, m_tvalid_o, m_tlast_o, busy_o, overflow_o;
  logic [15:0] frames_o;
  int checks = 0;
  int errors = 0;
  int exp_frames = 0;
  logic [6:0] mem [6];
  int cnt = 0;
  int m_fid = 0;
  logic bubble = 1'b0;

  vischain_ctrl #(.LENGTH(3), .WIDTH(7), .FBITS(16)) dut (
    .clock(clock), .reset(reset), .done_i(done_i),
    .chain_load_o(chain_load_o), .chain_shift_o(chain_shift_o),
    .chain_valid_i(chain_valid_i), .chain_data_i(chain_data_i),
    .m_tvalid_o(m_tvalid_o), .m_tready_i(m_tready_i), .m_tlast_o(m_tlast_o),
    .m_tdata_o(m_tdata_o), .busy_o(busy_o), .overflow_o(overflow_o), .frames_o(frames_o)
  );

  always #5 clock = ~clock;

  // Chain model: word k of frame f is f*8+k, loaded on chain_load_o, shifted on chain_shift_o.
  always @(posedge clock) begin
    if (chain_load_o) begin
      for (int k = 0; k < 6; k++) mem[k] <= 7'((m_fid + 1) * 8 + k);
      m_fid <= m_fid + 1;
      cnt <= 6;
    end else if (chain_shift_o) begin
      for (int k = 0; k < 5; k++) mem[k] <= mem[k + 1];
      mem[5] <= 7'd0;
      cnt <= cnt - 1;
    end
  end
  assign chain_valid_i = (cnt != 0) && !bubble;
  assign chain_data_i = mem[0];

  task automatic step;
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset;
    reset = 1'b1; done_i = 1'b0; m_tready_i = 1'b1; bubble = 1'b0;
    step; step;
    reset = 1'b0;
    #1;
    checks++;
    if ({chain_load_o, chain_shift_o, m_tvalid_o, m_tlast_o, busy_o, overflow_o} !== 6'b0) begin
      errors++;
      $display("FAIL reset_outputs got %b exp 000000",
               {chain_load_o, chain_shift_o, m_tvalid_o, m_tlast_o, busy_o, overflow_o});
    end
    checks++;
    if (frames_o !== 16'd0) begin errors++; $display("FAIL reset_frames got %0d exp 0", frames_o); end
  endtask

  task automatic test_basic;
    logic [4:0] exp_v;
    for (int c = 0; c < 20; c++) begin
      done_i = (c == 10);
      #1;
      exp_v = {c == 11, c >= 12 && c <= 17, c >= 12 && c <= 17, c == 17, c >= 11 && c <= 17};
      checks++;
      if ({chain_load_o, m_tvalid_o, chain_shift_o, m_tlast_o, busy_o} !== exp_v) begin
        errors++;
        $display("FAIL basic_c%0d load/valid/shift/last/busy got %b exp %b", c,
                 {chain_load_o, m_tvalid_o, chain_shift_o, m_tlast_o, busy_o}, exp_v);
      end
      if (c >= 12 && c <= 17) begin
        checks++;
        if (m_tdata_o !== 7'(m_fid * 8 + c - 12)) begin
          errors++;
          $display("FAIL basic_data_c%0d got %0d exp %0d", c, m_tdata_o, 7'(m_fid * 8 + c - 12));
        end
      end
      step;
    end
    done_i = 1'b0;
    exp_frames++;
    checks++;
    if (frames_o !== 16'(exp_frames)) begin errors++; $display("FAIL basic_frames got %0d exp %0d", frames_o, exp_frames); end
    checks++;
    if (overflow_o !== 1'b0) begin errors++; $display("FAIL basic_overflow got %b exp 0", overflow_o); end
  endtask

  task automatic test_backpressure;
    int hs_n = 0;
    done_i = 1'b1; step; done_i = 1'b0; step;
    for (int i = 0; i < 40 && hs_n < 6; i++) begin
      m_tready_i = i[0];
      #1;
      checks++;
      if (chain_shift_o !== (m_tvalid_o & m_tready_i)) begin
        errors++;
        $display("FAIL bp_shift_i%0d got %b exp %b", i, chain_shift_o, m_tvalid_o & m_tready_i);
      end
      if (m_tvalid_o) begin
        checks++;
        if (m_tdata_o !== 7'(m_fid * 8 + hs_n)) begin
          errors++;
          $display("FAIL bp_data_i%0d got %0d exp %0d", i, m_tdata_o, 7'(m_fid * 8 + hs_n));
        end
        if (m_tready_i) begin
          checks++;
          if (m_tlast_o !== (hs_n == 5)) begin
            errors++;
            $display("FAIL bp_last_hs%0d got %b exp %b", hs_n, m_tlast_o, hs_n == 5);
          end
          hs_n++;
        end
      end
      step;
    end
    m_tready_i = 1'b1;
    #1;
    exp_frames++;
    checks++;
    if (hs_n !== 6) begin errors++; $display("FAIL bp_handshakes got %0d exp 6", hs_n); end
    checks++;
    if (frames_o !== 16'(exp_frames) || busy_o !== 1'b0) begin
      errors++;
      $display("FAIL bp_end frames/busy got %0d/%b exp %0d/0", frames_o, busy_o, exp_frames);
    end
  endtask

  task automatic test_bubble;
    int hs_n = 0;
    int bub = 0;
    done_i = 1'b1; step; done_i = 1'b0; step;
    for (int i = 0; i < 30 && hs_n < 6; i++) begin
      bubble = (hs_n == 2) && (bub < 3);
      #1;
      if (bubble) begin
        bub++;
        checks++;
        if ({m_tvalid_o, chain_shift_o} !== 2'b00) begin
          errors++;
          $display("FAIL bubble_i%0d valid/shift got %b exp 00", i, {m_tvalid_o, chain_shift_o});
        end
      end else if (m_tvalid_o) begin
        checks++;
        if (m_tdata_o !== 7'(m_fid * 8 + hs_n) || m_tlast_o !== (hs_n == 5)) begin
          errors++;
          $display("FAIL bubble_word%0d data/last got %0d/%b exp %0d/%b", hs_n, m_tdata_o, m_tlast_o,
                   7'(m_fid * 8 + hs_n), hs_n == 5);
        end
        hs_n++;
      end
      step;
    end
    bubble = 1'b0;
    exp_frames++;
    checks++;
    if (bub !== 3 || hs_n !== 6) begin errors++; $display("FAIL bubble_counts bub/words got %0d/%0d exp 3/6", bub, hs_n); end
    checks++;
    if (frames_o !== 16'(exp_frames)) begin errors++; $display("FAIL bubble_frames got %0d exp %0d", frames_o, exp_frames); end
  endtask

  task automatic test_back_to_back;
    int hs_n = 0;
    int hs2 = 0;
    done_i = 1'b1; step; done_i = 1'b0; step;
    for (int i = 0; i < 20 && hs_n < 6; i++) begin
      #1;
      if (m_tvalid_o) begin
        hs_n++;
        if (m_tlast_o) done_i = 1'b1;
      end
      step;
      done_i = 1'b0;
    end
    #1;
    checks++;
    if (hs_n !== 6 || chain_load_o !== 1'b1) begin
      errors++;
      $display("FAIL b2b_reload words/load got %0d/%b exp 6/1", hs_n, chain_load_o);
    end
    step;
    for (int i = 0; i < 20 && hs2 < 6; i++) begin
      #1;
      if (m_tvalid_o) begin
        checks++;
        if (m_tdata_o !== 7'(m_fid * 8 + hs2) || m_tlast_o !== (hs2 == 5)) begin
          errors++;
          $display("FAIL b2b_word%0d data/last got %0d/%b exp %0d/%b", hs2, m_tdata_o, m_tlast_o,
                   7'(m_fid * 8 + hs2), hs2 == 5);
        end
        hs2++;
      end
      step;
    end
    exp_frames += 2;
    checks++;
    if (frames_o !== 16'(exp_frames) || overflow_o !== 1'b0 || hs2 !== 6) begin
      errors++;
      $display("FAIL b2b_end frames/overflow/words got %0d/%b/%0d exp %0d/0/6", frames_o, overflow_o, hs2, exp_frames);
    end
  endtask

  task automatic test_overflow;
    int hs_n = 0;
    done_i = 1'b1; step;
    done_i = 1'b1; step;
    done_i = 1'b0;
    #1;
    checks++;
    if (overflow_o !== 1'b1 || chain_load_o !== 1'b0) begin
      errors++;
      $display("FAIL ovf_load overflow/load got %b/%b exp 1/0", overflow_o, chain_load_o);
    end
    for (int i = 0; i < 20 && hs_n < 6; i++) begin
      #1;
      if (m_tvalid_o) begin
        if (hs_n == 2) done_i = 1'b1;
        hs_n++;
      end
      step;
      done_i = 1'b0;
    end
    #1;
    exp_frames++;
    checks++;
    if (hs_n !== 6 || overflow_o !== 1'b1 || busy_o !== 1'b0) begin
      errors++;
      $display("FAIL ovf_end words/overflow/busy got %0d/%b/%b exp 6/1/0", hs_n, overflow_o, busy_o);
    end
    checks++;
    if (frames_o !== 16'(exp_frames)) begin errors++; $display("FAIL ovf_frames got %0d exp %0d", frames_o, exp_frames); end
  endtask

  task automatic test_reset_mid;
    int hs_n = 0;
    done_i = 1'b1; step; done_i = 1'b0; step;
    for (int i = 0; i < 20 && hs_n < 2; i++) begin
      #1;
      if (m_tvalid_o) hs_n++;
      step;
    end
    reset = 1'b1; step; reset = 1'b0;
    #1;
    checks++;
    if ({chain_load_o, chain_shift_o, m_tvalid_o, m_tlast_o, busy_o, overflow_o} !== 6'b0 || frames_o !== 16'd0) begin
      errors++;
      $display("FAIL midreset outputs got %b frames %0d exp 000000 frames 0",
               {chain_load_o, chain_shift_o, m_tvalid_o, m_tlast_o, busy_o, overflow_o}, frames_o);
    end
    hs_n = 0;
    done_i = 1'b1; step; done_i = 1'b0; step;
    for (int i = 0; i < 20 && hs_n < 6; i++) begin
      #1;
      if (m_tvalid_o) begin
        checks++;
        if (m_tdata_o !== 7'(m_fid * 8 + hs_n) || m_tlast_o !== (hs_n == 5)) begin
          errors++;
          $display("FAIL midreset_word%0d data/last got %0d/%b exp %0d/%b", hs_n, m_tdata_o, m_tlast_o,
                   7'(m_fid * 8 + hs_n), hs_n == 5);
        end
        hs_n++;
      end
      step;
    end
    checks++;
    if (hs_n !== 6 || frames_o !== 16'd1) begin
      errors++;
      $display("FAIL midreset_end words/frames got %0d/%0d exp 6/1", hs_n, frames_o);
    end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_backpressure;
    test_bubble;
    test_back_to_back;
    test_overflow;
    test_reset_mid;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/vischain_ctrl.md
Name: vischain_ctrl

Overview:
- Sequences one chain of correlator visibility units.
- On an accumulation-done strobe, pulses the chain load so every unit captures its re/im pair, then drains the chain one word per downstream handshake onto a valid/ready stream.
- Sits between the correlator array's accumulation timer and the visibility readout/framing logic.
- Owns all chain load and shift timing; the datapath does none of its own sequencing.

Parameters:
- LENGTH, 3: number of correlator units in the chain; one frame is 2*LENGTH words.
- WIDTH, 7: data word width in bits.
- FBITS, 16: width of the completed-frame counter.

Ports:
- clock  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- done_i  in  1  single-cycle accumulation-complete strobe.
- chain_load_o  out  1  to all chain units: capture re/im this cycle.
- chain_shift_o  out  1  to all chain units: advance chain by one word this cycle.
- chain_valid_i  in  1  valid from the last chain element.
- chain_data_i  in  WIDTH  data from the last chain element.
- m_tvalid_o  out  1  stream valid.
- m_tready_i  in  1  stream ready.
- m_tlast_o  out  1  final word of frame.
- m_tdata_o  out  WIDTH  stream data.
- busy_o  out  1  high whenever state is not IDLE.
- overflow_o  out  1  sticky: a done_i strobe was dropped.
- frames_o  out  FBITS  count of completed frames.

Behaviour:
- All registers are reset synchronously when reset=1 on a rising edge; reset overrides all other inputs.
- Reset values:
  - state=IDLE, idx=0, frames_o=0, overflow_o=0.
  - Therefore chain_load_o=0, chain_shift_o=0, m_tvalid_o=0, m_tlast_o=0, busy_o=0.
- State machine:
  - IDLE: done_i=1 -> LOAD.
  - LOAD: chain_load_o=1 for exactly this one cycle; idx<=0; -> DRAIN unconditionally.
  - DRAIN, outputs:
    - m_tvalid_o = chain_valid_i.
    - m_tdata_o = chain_data_i (combinational pass-through).
    - m_tlast_o = m_tvalid_o & (idx==2*LENGTH-1).
  - DRAIN, handshake hs = m_tvalid_o & m_tready_i:
    - chain_shift_o = hs, in the same cycle.
    - On hs, idx increments.
    - On hs with m_tlast_o: frames_o increments (wraps modulo 2^FBITS); next state is IDLE, or LOAD if done_i=1 that same cycle (back-to-back frames).
- Latency: done_i at cycle t -> chain_load_o at t+1 -> first word may be valid at t+2.
- Backpressure:
  - m_tready_i=0 holds idx and the chain; chain_shift_o=0.
  - m_tdata_o is stable while valid and not ready, because the chain does not shift.
- Chain bubble: chain_valid_i=0 in DRAIN drops m_tvalid_o, and no shift occurs. This is not an error; the controller waits.
- m_tvalid_o, m_tlast_o and chain_shift_o are 0 outside DRAIN; m_tdata_o is don't-care there.
- Dropped strobes:
  - done_i=1 in LOAD, or in DRAIN except on the final-handshake cycle, is dropped and sets overflow_o.
  - overflow_o clears only on reset.
- Reset mid-DRAIN: frame abandoned, no m_tlast_o emitted, frames_o=0; the chain contents are not flushed by the controller.
- idx width is clog2(2*LENGTH); idx never exceeds 2*LENGTH-1.

Test Plan:
- LENGTH=3, m_tready_i=1, chain_valid_i=1, done_i pulse at cycle 10:
  - chain_load_o=1 at cycle 11 only.
  - m_tvalid_o=1 on cycles 12-17, chain_shift_o on the same cycles.
  - m_tlast_o on cycle 17; busy_o low from 18; frames_o=1.
- Same frame with m_tready_i low on alternate cycles:
  - exactly 6 handshakes, m_tdata_o stable while stalled, m_tlast_o only on the 6th handshake.
- chain_valid_i low for 3 cycles after the 2nd word:
  - m_tvalid_o low and no shift for 3 cycles; remaining 4 words follow; frames_o=1.
- done_i asserted on the final-handshake cycle:
  - next cycle chain_load_o=1, second frame drains; frames_o=2; overflow_o=0.
- done_i asserted during LOAD, and again mid-DRAIN (word 3):
  - overflow_o=1 and stays high; the frame still completes normally with 6 words.
- reset=1 asserted after word 2 of DRAIN:
  - next cycle all outputs at reset values.
  - A following done_i yields a full 6-word frame; frames_o=1.
